mem_arbiter: RTL

Sequences and shares the byte-addressed unified RAM between the instruction-fetch line-refill path and the load/store unit. It accepts one request at a time over valid/ready handshakes and turns each request into RAM port cycles: one cycle for a line read, or one cycle per byte for a store. It returns the result with a one-cycle response pulse. It sits between the fetch/LSU front-ends and the RAM's address/read-line/write-byte port.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_rr.sv | 47 ++++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-RAM arbiter (fetch line refill vs. LSU).
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Size code 3 is treated as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-requester grant generator. With MEM_ARB_RR_EN a 1-bit pointer alternates ties,
// otherwise the LSU has fixed priority and no state exists.
module mem_arb_rr
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
`endif
    input  logic req_if,
    input  logic req_ls,
    output logic gnt_if,
    output logic gnt_ls
);

`ifdef MEM_ARB_RR_EN
    owner_t ptr_q, ptr_d;

    always_comb begin
        gnt_ls = req_ls && (!req_if || (ptr_q == OWN_LS));
        gnt_if = req_if && (!req_ls || (ptr_q == OWN_IF));
    end

    // After any accept the pointer favours whoever was not just served.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = gnt_ls ? OWN_IF : OWN_LS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= OWN_LS;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_ls = req_ls;
        gnt_if = req_if && !req_ls;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-addressed unified RAM between fetch line reads and LSU loads/stores.
// Define MEM_ARB_RR_EN for round-robin ties; default build gives the LSU fixed priority.
//
// state    | meaning
// ST_IDLE  | waiting; ready asserted for the granted requester, RAM port quiet
// ST_READ  | one RAM line read at the latched address, response captured
// ST_WRITE | one byte written per cycle at addr+k, response after the last byte
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_resp_valid,
    output logic [LINE_WIDTH-1:0] if_resp_line,
    input  logic                  ls_req_valid,
    input  logic                  ls_req_we,
    input  logic [1:0]            ls_req_size,
    input  logic [ADDR_WIDTH-1:0] ls_req_addr,
    input  logic [31:0]           ls_req_wdata,
    output logic                  ls_req_ready,
    output logic                  ls_resp_valid,
    output logic [31:0]           ls_resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            k_q, k_d;
    logic                  if_resp_valid_q, if_resp_valid_d;
    logic [LINE_WIDTH-1:0] if_resp_line_q, if_resp_line_d;
    logic                  ls_resp_valid_q, ls_resp_valid_d;
    logic [31:0]           ls_resp_rdata_q, ls_resp_rdata_d;

    logic        gnt_if, gnt_ls;
    logic        idle;
    logic [31:0] load_data;
    logic        last_byte;

    assign idle         = (state_q == ST_IDLE);
    assign if_req_ready = idle && gnt_if;
    assign ls_req_ready = idle && gnt_ls;

    mem_arb_rr u_rr (
`ifdef MEM_ARB_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (if_req_ready || ls_req_ready),
`endif
        .req_if (if_req_valid),
        .req_ls (ls_req_valid),
        .gnt_if (gnt_if),
        .gnt_ls (gnt_ls)
    );

    always_comb begin
        case (size_q)
            SIZE_B:  load_data = {24'd0, mem_rdata[7:0]};
            SIZE_H:  load_data = {16'd0, mem_rdata[15:0]};
            default: load_data = mem_rdata[31:0];
        endcase
    end

    assign last_byte = ({1'b0, k_q} == (size_bytes(size_q) - 3'd1));

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        size_d          = size_q;
        wdata_d         = wdata_q;
        k_d             = k_q;
        if_resp_valid_d = 1'b0;
        if_resp_line_d  = if_resp_line_q;
        ls_resp_valid_d = 1'b0;
        ls_resp_rdata_d = ls_resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req_ready) begin
                    owner_d = OWN_IF;
                    addr_d  = if_req_addr;
                    state_d = ST_READ;
                end else if (ls_req_ready) begin
                    owner_d = OWN_LS;
                    addr_d  = ls_req_addr;
                    size_d  = ls_req_size;
                    wdata_d = ls_req_wdata;
                    k_d     = 2'd0;
                    state_d = ls_req_we ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_IDLE;
                if (owner_q == OWN_IF) begin
                    if_resp_valid_d = 1'b1;
                    if_resp_line_d  = mem_rdata;
                end else begin
                    ls_resp_valid_d = 1'b1;
                    ls_resp_rdata_d = load_data;
                end
            end
            ST_WRITE: begin
                k_d = k_q + 2'd1;
                if (last_byte) begin
                    state_d         = ST_IDLE;
                    ls_resp_valid_d = 1'b1;
                    ls_resp_rdata_d = 32'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM port is decoded from registered state so reset silences it immediately.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_READ) begin
            mem_addr = addr_q;
        end else if (state_q == ST_WRITE) begin
            mem_we   = 1'b1;
            mem_addr = addr_q + ADDR_WIDTH'(k_q);
            case (k_q)
                2'd0:    mem_wdata = wdata_q[7:0];
                2'd1:    mem_wdata = wdata_q[15:8];
                2'd2:    mem_wdata = wdata_q[23:16];
                default: mem_wdata = wdata_q[31:24];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_LS;
            addr_q          <= '0;
            size_q          <= SIZE_B;
            wdata_q         <= '0;
            k_q             <= '0;
            if_resp_valid_q <= 1'b0;
            if_resp_line_q  <= '0;
            ls_resp_valid_q <= 1'b0;
            ls_resp_rdata_q <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            addr_q          <= addr_d;
            size_q          <= size_d;
            wdata_q         <= wdata_d;
            k_q             <= k_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_resp_line_q  <= if_resp_line_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            ls_resp_rdata_q <= ls_resp_rdata_d;
        end
    end

    assign if_resp_valid = if_resp_valid_q;
    assign if_resp_line  = if_resp_line_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign ls_resp_rdata = ls_resp_rdata_q;

endmodule
